tdc_gpx_bus_interface: RTL and testbench
========================================

# tdc_gpx_bus_interface

Physical bus responder for the TDC-GPX register/FIFO port. Accepts single-cycle memory-operation strobes from the TDC-GPX core controller (address, 28-bit data, read/write select). Executes each strobe as one timed asynchronous-bus cycle on the chip pins (ADR, D, CSN, RDN, WRN, OEN). For reads, returns the captured word with a one-cycle `rw_data_ready` pulse. Sits between the core controller and the top-level pad tristates.

## Interface
Parameters:
- `T_SETUP`, 1, cycles of address/CSN (and write data) valid before the strobe falls; legal 1..15
- `T_PULSE`, 2, cycles RDN/WRN are held low; legal 1..15
- `T_HOLD`, 1, cycles address/data/CSN are held after the strobe rises; legal 1..15
- `T_RECOVER`, 2, cycles of CSN high and bus released before the next access; legal 1..15

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `rw_mem_op`  in  1  one-cycle operation strobe from the controller
- `rw_read_write`  in  1  1 = read, 0 = write; sampled with `rw_mem_op`
- `rw_addr`  in  4  TDC-GPX register address; sampled with `rw_mem_op`
- `rw_data_in`  in  28  write data; sampled with `rw_mem_op`
- `rw_ready`  out  1  high when idle and able to accept `rw_mem_op`
- `rw_data_out`  out  28  last read word; holds until the next read completes
- `rw_data_ready`  out  1  one-cycle pulse when `rw_data_out` is updated
- `op_dropped`  out  1  sticky; set when `rw_mem_op` arrives while busy
- `tdc_adr`  out  4  chip address pins
- `tdc_d_out`  out  28  data toward chip
- `tdc_d_oe`  out  1  pad tristate enable for `tdc_d_out`
- `tdc_d_in`  in  28  data from chip pads
- `tdc_csn`, `tdc_rdn`, `tdc_wrn`, `tdc_oen`  out  1 each  active-low chip select, read strobe, write strobe, chip output enable

## Operation
- All outputs are registered.
- Reset values: `rw_ready`=1, `rw_data_out`=0, `rw_data_ready`=0, `op_dropped`=0, `tdc_adr`=0, `tdc_d_out`=0, `tdc_d_oe`=0, `tdc_csn`=`tdc_rdn`=`tdc_wrn`=`tdc_oen`=1.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER. A single 4-bit down-counter is loaded with (parameter − 1) on entry to each state. The state exits when the counter reads 0.
- IDLE: when `rw_mem_op`=1, latch address, data and direction, then go to SETUP. `rw_ready` goes 0 on the same edge.
- SETUP: `tdc_csn`=0 and `tdc_adr` is driven.
  - Write: `tdc_d_out` is driven and `tdc_d_oe`=1.
  - Read: `tdc_oen`=0 and `tdc_d_oe`=0.
- STROBE: SETUP outputs are held. `tdc_wrn`=0 (write) or `tdc_rdn`=0 (read).
  - Read: on the last STROBE cycle, `tdc_d_in` is registered into a capture register.
- HOLD: strobe returns high. `tdc_csn`, address, data and `tdc_oen` are held.
- RECOVER: `tdc_csn`=1, `tdc_oen`=1, `tdc_d_oe`=0.
  - Read: `rw_data_out` is loaded from the capture register and `rw_data_ready` pulses on the first RECOVER cycle.
  - After RECOVER, return to IDLE with `rw_ready`=1.
- `rw_mem_op` seen while not IDLE, or on the same cycle `rw_ready` is 0: the operation is ignored and `op_dropped` is set. `op_dropped` clears only on reset.
- Invariant: `tdc_d_oe`=1 and `tdc_oen`=0 are never true in the same cycle (no bus contention).
- Invariant: `tdc_rdn` and `tdc_wrn` are never both 0.
- Reset mid-operation: on the next edge all strobes go high, `tdc_d_oe`=0, state returns to IDLE. The transfer is abandoned, no `rw_data_ready` is issued, and `rw_data_out` is cleared.

## Timing
- `rw_mem_op` is sampled at edge k. The pins show SETUP from edge k+1.
- Busy time is T_SETUP+T_PULSE+T_HOLD+T_RECOVER cycles; `rw_ready` is 0 for exactly this many cycles. With defaults, this is 6 cycles.
- Strobe low width is exactly T_PULSE cycles.
- Read capture is at edge k+T_SETUP+T_PULSE.
- `rw_data_ready` is high for the cycle beginning at edge k+T_SETUP+T_PULSE+T_HOLD+1.
- Fastest back-to-back: a new `rw_mem_op` is accepted on the first cycle `rw_ready`=1. There are no idle gaps beyond RECOVER.
- Writes produce no `rw_data_ready`.

## Test plan
- Write: addr 0, data 28'h007FC81, defaults.
  - `tdc_csn` low for 4 cycles and `tdc_wrn` low for 2 cycles; `tdc_d_out`=007FC81 with `tdc_d_oe`=1 throughout CSN low; `tdc_oen` stays 1.
  - `rw_ready` low for 6 cycles; no `rw_data_ready`.
- Read: addr 8, `tdc_d_in`=28'h0ABCDEF stable during the strobe.
  - `tdc_oen`=0, `tdc_rdn` low for 2 cycles, `tdc_d_oe`=0.
  - `rw_data_ready` pulses once at edge k+5 with `rw_data_out`=0ABCDEF.
- Back-to-back: write reg 4 with 28'h6400000, then a read issued on the first `rw_ready`=1 cycle.
  - Both complete; no `op_dropped`; CSN is high for ≥2 cycles between accesses.
- Busy strobe: `rw_mem_op` pulsed 2 cycles after a read starts.
  - Second operation ignored; `op_dropped`=1 and sticky; the first read completes normally.
- Reset mid-strobe: reset asserted during STROBE of a read.
  - Next cycle: all strobes high, `tdc_d_oe`=0, `rw_ready`=1, `rw_data_out`=0, no `rw_data_ready`.
- Parameter override T_SETUP=2, T_PULSE=4, T_HOLD=3, T_RECOVER=1.
  - RDN low exactly 4 cycles, busy 10 cycles, `rw_data_ready` at edge k+10.

Source files
------------

// File: rtl/tdc_gpx_bus_interface_if.sv
// Controller-side handshake and TDC-GPX pin bundle for the bus responder.
interface tdc_gpx_bus_interface_if;
  localparam int unsigned ADR_W = 4;
  localparam int unsigned DAT_W = 28;

  // Controller strobe side
  logic             rw_mem_op;
  logic             rw_read_write;
  logic [ADR_W-1:0] rw_addr;
  logic [DAT_W-1:0] rw_data_in;
  logic             rw_ready;
  logic [DAT_W-1:0] rw_data_out;
  logic             rw_data_ready;
  logic             op_dropped;

  // Chip pin side (toward pad tristates)
  logic [ADR_W-1:0] tdc_adr;
  logic [DAT_W-1:0] tdc_d_out;
  logic             tdc_d_oe;
  logic [DAT_W-1:0] tdc_d_in;
  logic             tdc_csn;
  logic             tdc_rdn;
  logic             tdc_wrn;
  logic             tdc_oen;

  // Bus responder view
  modport slave (
    input  rw_mem_op, rw_read_write, rw_addr, rw_data_in, tdc_d_in,
    output rw_ready, rw_data_out, rw_data_ready, op_dropped,
           tdc_adr, tdc_d_out, tdc_d_oe, tdc_csn, tdc_rdn, tdc_wrn, tdc_oen
  );

  // Core controller / pad view
  modport master (
    output rw_mem_op, rw_read_write, rw_addr, rw_data_in, tdc_d_in,
    input  rw_ready, rw_data_out, rw_data_ready, op_dropped,
           tdc_adr, tdc_d_out, tdc_d_oe, tdc_csn, tdc_rdn, tdc_wrn, tdc_oen
  );
endinterface

// File: rtl/tdc_gpx_bus_interface.sv
// TDC-GPX asynchronous bus responder: turns one-cycle memory-op strobes into
// timed SETUP/STROBE/HOLD/RECOVER pin cycles. Pins are registered from the
// current state, so they trail the FSM state by one clock.
module tdc_gpx_bus_interface #(
  parameter int unsigned T_SETUP   = 1,
  parameter int unsigned T_PULSE   = 2,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned T_RECOVER = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  tdc_gpx_bus_interface_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ADR_W = 4;
  localparam int unsigned DAT_W = 28;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(T_RECOVER - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Latched operation
  logic             rd_q, rd_d;
  logic [ADR_W-1:0] addr_q, addr_d;
  logic [DAT_W-1:0] data_q, data_d;
  logic [DAT_W-1:0] cap_q, cap_d;

  // Controller-facing outputs
  logic             rw_ready_q, rw_ready_d;
  logic [DAT_W-1:0] rw_data_out_q, rw_data_out_d;
  logic             rw_data_ready_q, rw_data_ready_d;
  logic             op_dropped_q, op_dropped_d;

  // Pin outputs
  logic [ADR_W-1:0] tdc_adr_q, tdc_adr_d;
  logic [DAT_W-1:0] tdc_d_out_q, tdc_d_out_d;
  logic             tdc_d_oe_q, tdc_d_oe_d;
  logic             tdc_csn_q, tdc_csn_d;
  logic             tdc_rdn_q, tdc_rdn_d;
  logic             tdc_wrn_q, tdc_wrn_d;
  logic             tdc_oen_q, tdc_oen_d;

  // Decoded helpers
  logic last_c;
  logic active_c;
  logic first_rec_c;
  logic accept_c;

  assign last_c      = (cnt_q == '0);
  assign active_c    = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                       (state_q == ST_HOLD);
  assign first_rec_c = (state_q == ST_RECOVER) && (cnt_q == RECOVER_LD);
  assign accept_c    = (state_q == ST_IDLE) && bus.rw_mem_op;

  // FSM state and phase counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: each phase runs until the down-counter reaches zero
  always_comb begin
    state_d = state_q;
    cnt_d   = last_c ? cnt_q : cnt_q - CNT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.rw_mem_op) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (last_c) begin
          state_d = ST_STROBE;
          cnt_d   = PULSE_LD;
        end
      end
      ST_STROBE: begin
        if (last_c) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (last_c) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVER_LD;
        end
      end
      ST_RECOVER: begin
        if (last_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Operation latch, read capture, controller handshake and pin values
  always_comb begin
    rd_d            = rd_q;
    addr_d          = addr_q;
    data_d          = data_q;
    cap_d           = cap_q;
    rw_data_out_d   = rw_data_out_q;
    rw_data_ready_d = 1'b0;
    op_dropped_d    = op_dropped_q;
    tdc_adr_d       = tdc_adr_q;
    tdc_d_out_d     = tdc_d_out_q;

    if (accept_c) begin
      rd_d   = bus.rw_read_write;
      addr_d = bus.rw_addr;
      data_d = bus.rw_data_in;
    end

    // Any strobe outside IDLE is lost; the flag stays up until reset
    if (bus.rw_mem_op && (state_q != ST_IDLE)) begin
      op_dropped_d = 1'b1;
    end

    // Sample the chip data on the final strobe-phase clock
    if ((state_q == ST_STROBE) && last_c && rd_q) begin
      cap_d = bus.tdc_d_in;
    end

    if (first_rec_c && rd_q) begin
      rw_data_out_d   = cap_q;
      rw_data_ready_d = 1'b1;
    end

    // Address and write data hold their last driven value when idle
    if (active_c) begin
      tdc_adr_d = addr_q;
      if (!rd_q) begin
        tdc_d_out_d = data_q;
      end
    end

    // Direction is fixed for the whole access, so OE and OEN never overlap
    tdc_csn_d  = !active_c;
    tdc_d_oe_d = active_c && !rd_q;
    tdc_oen_d  = !(active_c && rd_q);
    tdc_rdn_d  = !((state_q == ST_STROBE) && rd_q);
    tdc_wrn_d  = !((state_q == ST_STROBE) && !rd_q);

    rw_ready_d = (state_d == ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q            <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      cap_q           <= '0;
      rw_ready_q      <= 1'b1;
      rw_data_out_q   <= '0;
      rw_data_ready_q <= 1'b0;
      op_dropped_q    <= 1'b0;
      tdc_adr_q       <= '0;
      tdc_d_out_q     <= '0;
      tdc_d_oe_q      <= 1'b0;
      tdc_csn_q       <= 1'b1;
      tdc_rdn_q       <= 1'b1;
      tdc_wrn_q       <= 1'b1;
      tdc_oen_q       <= 1'b1;
    end else begin
      rd_q            <= rd_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      cap_q           <= cap_d;
      rw_ready_q      <= rw_ready_d;
      rw_data_out_q   <= rw_data_out_d;
      rw_data_ready_q <= rw_data_ready_d;
      op_dropped_q    <= op_dropped_d;
      tdc_adr_q       <= tdc_adr_d;
      tdc_d_out_q     <= tdc_d_out_d;
      tdc_d_oe_q      <= tdc_d_oe_d;
      tdc_csn_q       <= tdc_csn_d;
      tdc_rdn_q       <= tdc_rdn_d;
      tdc_wrn_q       <= tdc_wrn_d;
      tdc_oen_q       <= tdc_oen_d;
    end
  end

  assign bus.rw_ready      = rw_ready_q;
  assign bus.rw_data_out   = rw_data_out_q;
  assign bus.rw_data_ready = rw_data_ready_q;
  assign bus.op_dropped    = op_dropped_q;
  assign bus.tdc_adr       = tdc_adr_q;
  assign bus.tdc_d_out     = tdc_d_out_q;
  assign bus.tdc_d_oe      = tdc_d_oe_q;
  assign bus.tdc_csn       = tdc_csn_q;
  assign bus.tdc_rdn       = tdc_rdn_q;
  assign bus.tdc_wrn       = tdc_wrn_q;
  assign bus.tdc_oen       = tdc_oen_q;

endmodule

// File: tb/tb_tdc_gpx_bus_interface.sv
// Bench for tdc_gpx_bus_interface: a default-timing and an overridden-timing
// instance share one stimulus stream and are both tracked by a timeline model.
module tb_tdc_gpx_bus_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        op;
  logic        rdw;
  logic [3:0]  addr;
  logic [27:0] wdata;
  logic [27:0] din;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_gpx_bus_interface_if bus0 ();
  tdc_gpx_bus_interface_if bus1 ();

  assign bus0.rw_mem_op     = op;
  assign bus0.rw_read_write = rdw;
  assign bus0.rw_addr       = addr;
  assign bus0.rw_data_in    = wdata;
  assign bus0.tdc_d_in      = din;
  assign bus1.rw_mem_op     = op;
  assign bus1.rw_read_write = rdw;
  assign bus1.rw_addr       = addr;
  assign bus1.rw_data_in    = wdata;
  assign bus1.tdc_d_in      = din;

  tdc_gpx_bus_interface u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  tdc_gpx_bus_interface #(
    .T_SETUP   (2),
    .T_PULSE   (4),
    .T_HOLD    (3),
    .T_RECOVER (1)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct packed {
    logic        rdy;
    logic [27:0] dout;
    logic        drdy;
    logic        drop;
    logic [3:0]  adr;
    logic [27:0] dq;
    logic        oe;
    logic        csn;
    logic        rdn;
    logic        wrn;
    logic        oen;
  } obs_t;

  obs_t obs [2];
  assign obs[0] = {bus0.rw_ready, bus0.rw_data_out, bus0.rw_data_ready, bus0.op_dropped,
                   bus0.tdc_adr, bus0.tdc_d_out, bus0.tdc_d_oe, bus0.tdc_csn,
                   bus0.tdc_rdn, bus0.tdc_wrn, bus0.tdc_oen};
  assign obs[1] = {bus1.rw_ready, bus1.rw_data_out, bus1.rw_data_ready, bus1.op_dropped,
                   bus1.tdc_adr, bus1.tdc_d_out, bus1.tdc_d_oe, bus1.tdc_csn,
                   bus1.tdc_rdn, bus1.tdc_wrn, bus1.tdc_oen};

  function automatic int ts(input int d); return (d != 0) ? 2 : 1; endfunction
  function automatic int tp(input int d); return (d != 0) ? 4 : 2; endfunction
  function automatic int th(input int d); return (d != 0) ? 3 : 1; endfunction
  function automatic int tr(input int d); return (d != 0) ? 1 : 2; endfunction
  function automatic int busy(input int d); return ts(d) + tp(d) + th(d) + tr(d); endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Timeline model: an access accepted at edge k occupies fixed offsets from k
  bit          kv_m   [2] = '{1'b0, 1'b0};
  int          k_m    [2] = '{0, 0};
  bit          rd_m   [2] = '{1'b0, 1'b0};
  logic [3:0]  adr_m  [2] = '{4'h0, 4'h0};
  logic [27:0] dat_m  [2] = '{28'h0, 28'h0};
  bit          drop_m [2] = '{1'b0, 1'b0};
  logic [27:0] dout_m [2] = '{28'h0, 28'h0};
  bit          pv_m   [2] = '{1'b0, 1'b0};
  int          pc_m   [2] = '{0, 0};
  logic [27:0] pval_m [2] = '{28'h0, 28'h0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   t;
      bit   act, stb, rdy_e, drdy_e;
      obs_t o;
      o      = obs[d];
      t      = cyc - k_m[d];
      act    = kv_m[d] && (t >= 1) && (t <= ts(d) + tp(d) + th(d));
      stb    = kv_m[d] && (t >= ts(d) + 1) && (t <= ts(d) + tp(d));
      rdy_e  = !(kv_m[d] && (t >= 0) && (t < busy(d)));
      drdy_e = pv_m[d] && (pc_m[d] == cyc);
      if (drdy_e) begin
        dout_m[d] = pval_m[d];
        pv_m[d]   = 1'b0;
      end
      check_eq($sformatf("d%0d_ready", d), 32'(o.rdy), 32'(rdy_e));
      check_eq($sformatf("d%0d_csn", d), 32'(o.csn), 32'(!act));
      check_eq($sformatf("d%0d_oen", d), 32'(o.oen), 32'(!(act && rd_m[d])));
      check_eq($sformatf("d%0d_d_oe", d), 32'(o.oe), 32'(act && !rd_m[d]));
      check_eq($sformatf("d%0d_rdn", d), 32'(o.rdn), 32'(!(stb && rd_m[d])));
      check_eq($sformatf("d%0d_wrn", d), 32'(o.wrn), 32'(!(stb && !rd_m[d])));
      check_eq($sformatf("d%0d_data_ready", d), 32'(o.drdy), 32'(drdy_e));
      check_eq($sformatf("d%0d_data_out", d), 32'(o.dout), 32'(dout_m[d]));
      check_eq($sformatf("d%0d_dropped", d), 32'(o.drop), 32'(drop_m[d]));
      if (act) check_eq($sformatf("d%0d_adr", d), 32'(o.adr), 32'(adr_m[d]));
      if (act && !rd_m[d]) check_eq($sformatf("d%0d_d_out", d), 32'(o.dq), 32'(dat_m[d]));

      // Effects of the inputs sampled at the coming edge
      if (kv_m[d] && rd_m[d] && (cyc + 1 == k_m[d] + ts(d) + tp(d))) begin
        pv_m[d]   = 1'b1;
        pc_m[d]   = k_m[d] + ts(d) + tp(d) + th(d) + 1;
        pval_m[d] = din;
      end
      if (reset) begin
        kv_m[d]   = 1'b0;
        drop_m[d] = 1'b0;
        dout_m[d] = 28'h0;
        pv_m[d]   = 1'b0;
      end else if (op) begin
        if (rdy_e) begin
          kv_m[d]  = 1'b1;
          k_m[d]   = cyc + 1;
          rd_m[d]  = rdw;
          adr_m[d] = addr;
          dat_m[d] = wdata;
        end else begin
          drop_m[d] = 1'b1;
        end
      end
    end
  end

  // One-cycle strobe; returns in the cycle that starts at the accepting edge
  task automatic issue(input logic r, input logic [3:0] a, input logic [27:0] w);
    op = 1'b1; rdw = r; addr = a; wdata = w;
    @(posedge clk); #1;
    op = 1'b0;
  endtask

  task automatic wait_ready(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (obs[d].rdy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check_eq($sformatf("d%0d_wait_ready_timeout", d), 32'(ok), 32'd1);
  endtask

  task automatic measure(input int d, input int n, input logic [27:0] wexp,
                         output int c_csn, output int c_rdn, output int c_wrn,
                         output int c_oen, output int c_oe, output int c_busy,
                         output int c_dr, output int dr_off, output logic [27:0] dr_val,
                         output int c_dqbad);
    obs_t o;
    c_csn = 0; c_rdn = 0; c_wrn = 0; c_oen = 0; c_oe = 0; c_busy = 0;
    c_dr = 0; dr_off = -1; dr_val = 28'h0; c_dqbad = 0;
    for (int i = 0; i < n; i++) begin
      o = obs[d];
      if (!o.csn) c_csn++;
      if (!o.rdn) c_rdn++;
      if (!o.wrn) c_wrn++;
      if (!o.oen) c_oen++;
      if (o.oe) c_oe++;
      if (o.oe && (o.dq !== wexp)) c_dqbad++;
      if (!o.rdy) c_busy++;
      if (o.drdy) begin
        c_dr++;
        if (dr_off < 0) dr_off = i;
        dr_val = o.dout;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c_csn, c_rdn, c_wrn, c_oen, c_oe, c_busy, c_dr, dr_off, c_dqbad;
    logic [27:0] dr_val;

    reset = 1'b1; op = 1'b0; rdw = 1'b0; addr = 4'h0; wdata = 28'h0; din = 28'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(bus0.rw_ready), 32'd1);
    check_eq("rst_csn", 32'(bus0.tdc_csn), 32'd1);
    check_eq("rst_d_oe", 32'(bus0.tdc_d_oe), 32'd0);
    check_eq("rst_data_out", 32'(bus0.rw_data_out), 32'd0);
    reset = 1'b0;

    // Write at default timing
    issue(1'b0, 4'h0, 28'h007FC81);
    measure(0, 12, 28'h007FC81, c_csn, c_rdn, c_wrn, c_oen, c_oe, c_busy, c_dr, dr_off, dr_val, c_dqbad);
    check_eq("wr_csn_low", 32'(c_csn), 32'd4);
    check_eq("wr_wrn_low", 32'(c_wrn), 32'd2);
    check_eq("wr_rdn_low", 32'(c_rdn), 32'd0);
    check_eq("wr_oe_high", 32'(c_oe), 32'd4);
    check_eq("wr_dq_bad", 32'(c_dqbad), 32'd0);
    check_eq("wr_oen_low", 32'(c_oen), 32'd0);
    check_eq("wr_busy", 32'(c_busy), 32'd6);
    check_eq("wr_data_ready", 32'(c_dr), 32'd0);

    // Read at default timing
    wait_ready(0); wait_ready(1);
    din = 28'h0ABCDEF;
    issue(1'b1, 4'h8, 28'h1234567);
    measure(0, 12, 28'h0, c_csn, c_rdn, c_wrn, c_oen, c_oe, c_busy, c_dr, dr_off, dr_val, c_dqbad);
    check_eq("rd_oen_low", 32'(c_oen), 32'd4);
    check_eq("rd_rdn_low", 32'(c_rdn), 32'd2);
    check_eq("rd_wrn_low", 32'(c_wrn), 32'd0);
    check_eq("rd_oe_high", 32'(c_oe), 32'd0);
    check_eq("rd_busy", 32'(c_busy), 32'd6);
    check_eq("rd_dr_count", 32'(c_dr), 32'd1);
    check_eq("rd_dr_offset", 32'(dr_off), 32'd5);
    check_eq("rd_dr_value", 32'(dr_val), 32'h0ABCDEF);

    // Read with overridden timing
    wait_ready(0); wait_ready(1);
    din = 28'h5A5A5A5;
    issue(1'b1, 4'h3, 28'h0);
    measure(1, 14, 28'h0, c_csn, c_rdn, c_wrn, c_oen, c_oe, c_busy, c_dr, dr_off, dr_val, c_dqbad);
    check_eq("ovr_rdn_low", 32'(c_rdn), 32'd4);
    check_eq("ovr_csn_low", 32'(c_csn), 32'd9);
    check_eq("ovr_busy", 32'(c_busy), 32'd10);
    check_eq("ovr_dr_offset", 32'(dr_off), 32'd10);
    check_eq("ovr_dr_value", 32'(dr_val), 32'h5A5A5A5);

    // Back-to-back: read issued on the first ready cycle after a write
    wait_ready(0); wait_ready(1);
    issue(1'b0, 4'h4, 28'h6400000);
    wait_ready(0);
    din = 28'h0123456;
    issue(1'b1, 4'h8, 28'h0);
    measure(0, 12, 28'h0, c_csn, c_rdn, c_wrn, c_oen, c_oe, c_busy, c_dr, dr_off, dr_val, c_dqbad);
    check_eq("b2b_dr_value", 32'(dr_val), 32'h0123456);
    check_eq("b2b_dropped", 32'(bus0.op_dropped), 32'd0);

    // Strobe while busy is dropped; the running read still completes
    wait_ready(0); wait_ready(1);
    din = 28'h0FEDCBA;
    issue(1'b1, 4'h2, 28'h0);
    @(posedge clk); #1;
    issue(1'b0, 4'h9, 28'h7777777);
    measure(0, 10, 28'h0, c_csn, c_rdn, c_wrn, c_oen, c_oe, c_busy, c_dr, dr_off, dr_val, c_dqbad);
    check_eq("busy_dropped", 32'(bus0.op_dropped), 32'd1);
    check_eq("busy_wrn_low", 32'(c_wrn), 32'd0);
    check_eq("busy_dr_value", 32'(dr_val), 32'h0FEDCBA);
    repeat (10) @(posedge clk);
    #1;
    check_eq("busy_dropped_sticky", 32'(bus0.op_dropped), 32'd1);

    // Reset while the read strobe is in progress
    wait_ready(0); wait_ready(1);
    din = 28'h0C0FFEE;
    issue(1'b1, 4'h5, 28'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_mid_rdn", 32'(bus0.tdc_rdn), 32'd1);
    check_eq("rst_mid_wrn", 32'(bus0.tdc_wrn), 32'd1);
    check_eq("rst_mid_csn", 32'(bus0.tdc_csn), 32'd1);
    check_eq("rst_mid_d_oe", 32'(bus0.tdc_d_oe), 32'd0);
    check_eq("rst_mid_ready", 32'(bus0.rw_ready), 32'd1);
    check_eq("rst_mid_data_out", 32'(bus0.rw_data_out), 32'd0);
    measure(0, 8, 28'h0, c_csn, c_rdn, c_wrn, c_oen, c_oe, c_busy, c_dr, dr_off, dr_val, c_dqbad);
    check_eq("rst_mid_no_dr", 32'(c_dr), 32'd0);

    // Random traffic, checked every cycle by the timeline model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      op    = ($urandom_range(0, 3) == 0);
      rdw   = 1'($urandom_range(0, 1));
      addr  = 4'($urandom);
      wdata = 28'($urandom);
      din   = 28'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    op    = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
